// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a four-instruction subset: ADDI, ADD, SUB, BNE.
// Define ILLEGAL_TRAP_EN to trap on illegal instructions; by default they retire as NOPs.
module multicycle_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] instr,
   input  logic             imem_ready,
   input  logic             EQ,
   output logic             imem_req,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             ALUctrl,
   output logic             ALUsrc,
   output logic             ImmSrc,
   output logic             PCsrc,
   output logic             PCWrite,
   output logic             trap,
   output logic [31:0]      instret
);

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StWb
`ifdef ILLEGAL_TRAP_EN
      , StTrap
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] ir_q;
   logic [31:0]      instret_q;
   // Holds fetch off until the first clock edge after reset release.
   logic             started_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_addi, is_add, is_sub, is_bne;
   logic       unused_ir;

   assign opcode    = ir_q[6:0];
   assign funct3    = ir_q[14:12];
   assign funct7    = ir_q[31:25];
   assign unused_ir = ^ir_q;

   assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
   assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
   assign is_bne  = (opcode == 7'b1100011) && (funct3 == 3'b001);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         ir_q      <= '0;
         instret_q <= '0;
         started_q <= 1'b0;
      end else begin
         started_q <= 1'b1;
         state_q   <= state_d;
         if (IRWrite) begin
            ir_q <= instr;
         end
         if (PCWrite) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUctrl  = 1'b0;
      ALUsrc   = 1'b0;
      ImmSrc   = 1'b0;
      PCsrc    = 1'b0;
      PCWrite  = 1'b0;
      trap     = 1'b0;
      unique case (state_q)
         StFetch: begin
            imem_req = started_q;
            if (started_q && imem_ready) begin
               IRWrite = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            state_d = StExec;
         end
         StExec: begin
            if (is_addi) begin
               ALUsrc  = 1'b1;
               state_d = StWb;
            end else if (is_add) begin
               state_d = StWb;
            end else if (is_sub) begin
               ALUctrl = 1'b1;
               state_d = StWb;
            end else if (is_bne) begin
               ALUctrl = 1'b1;
               ImmSrc  = 1'b1;
               PCWrite = 1'b1;
               PCsrc   = ~EQ;
               state_d = StFetch;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               state_d = StTrap;
`else
               PCWrite = 1'b1;
               state_d = StFetch;
`endif
            end
         end
         StWb: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            state_d  = StFetch;
         end
`ifdef ILLEGAL_TRAP_EN
         StTrap: begin
            trap = 1'b1;
         end
`endif
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams, all
// checked every cycle against a per-instruction schedule model of expected outputs.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        imem_ready = 1'b0;
   logic        EQ = 1'b0;
   logic        imem_req, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCWrite, trap;
   logic [31:0] instret;

   multicycle_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .imem_ready (imem_ready),
      .EQ         (EQ),
      .imem_req   (imem_req),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ALUctrl    (ALUctrl),
      .ALUsrc     (ALUsrc),
      .ImmSrc     (ImmSrc),
      .PCsrc      (PCsrc),
      .PCWrite    (PCWrite),
      .trap       (trap),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   localparam logic [8:0] B_REQ  = 9'h100;
   localparam logic [8:0] B_IRW  = 9'h080;
   localparam logic [8:0] B_REGW = 9'h040;
   localparam logic [8:0] B_ALUC = 9'h020;
   localparam logic [8:0] B_ALUS = 9'h010;
   localparam logic [8:0] B_IMMS = 9'h008;
   localparam logic [8:0] B_PCS  = 9'h004;
   localparam logic [8:0] B_PCW  = 9'h002;
   localparam logic [8:0] B_TRAP = 9'h001;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_BNE  = 32'hFE209EE3;

   logic [8:0] dut_vec;
   assign dut_vec = {imem_req, IRWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc, PCWrite, trap};

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: each fetched instruction schedules the output vectors of its remaining cycles.
   // kind 1 = branch cycle (PCsrc follows ~EQ), kind 2 = enters permanent trap afterwards.
   typedef struct {
      logic [8:0] vec;
      int         kind;
   } ent_t;

   ent_t        exp_q[$];
   bit          m_started;
   bit          m_trap;
   logic [31:0] m_instret;

   task automatic model_reset();
      exp_q.delete();
      m_started = 1'b0;
      m_trap    = 1'b0;
      m_instret = '0;
   endtask

   function automatic int classify(input logic [31:0] i);
      casez (i)
         32'b????????????_?????_000_?????_0010011: return 0;
         32'b0000000_?????_?????_000_?????_0110011: return 1;
         32'b0100000_?????_?????_000_?????_0110011: return 2;
         32'b???????_?????_?????_001_?????_1100011: return 3;
         default: return 4;
      endcase
   endfunction

   task automatic push(input logic [8:0] v, input int k);
      ent_t e;
      e.vec  = v;
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic schedule(input logic [31:0] i);
      push(9'h000, 0);
      case (classify(i))
         0: begin push(B_ALUS, 0); push(B_REGW | B_PCW, 0); end
         1: begin push(9'h000, 0); push(B_REGW | B_PCW, 0); end
         2: begin push(B_ALUC, 0); push(B_REGW | B_PCW, 0); end
         3: push(B_ALUC | B_IMMS | B_PCW, 1);
         default: begin
`ifdef ILLEGAL_TRAP_EN
            push(9'h000, 2);
`else
            push(B_PCW, 0);
`endif
         end
      endcase
   endtask

   task automatic cycle_check();
      logic [8:0] e;
      ent_t       en;
      bit         enter_trap;
      enter_trap = 1'b0;
      if (m_trap) begin
         e = B_TRAP;
      end else if (exp_q.size() == 0) begin
         e = m_started ? (B_REQ | (imem_ready ? B_IRW : 9'h000)) : 9'h000;
         if (m_started && imem_ready) schedule(instr);
      end else begin
         en = exp_q.pop_front();
         e  = en.vec;
         if (en.kind == 1 && !EQ) e = e | B_PCS;
         if (en.kind == 2) enter_trap = 1'b1;
      end
      chk("outputs", {23'd0, dut_vec}, {23'd0, e});
      chk("instret", instret, m_instret);
      if ((e & B_PCW) != 9'h000) m_instret = m_instret + 32'd1;
      m_started = 1'b1;
      if (enter_trap) m_trap = 1'b1;
   endtask

   task automatic step(input logic rdy, input logic [31:0] ins, input logic eq);
      @(posedge clk);
      #1;
      imem_ready = rdy;
      instr      = ins;
      EQ         = eq;
      @(negedge clk);
      cycle_check();
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      chk("req_low_before_edge", {31'd0, imem_req}, 32'd0);
      cycle_check();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      imem_ready = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {23'd0, dut_vec}, 32'd0);
      chk("reset_instret", instret, 32'd0);
      release_reset();
   endtask

   task automatic drain();
      for (int n = 0; n < 12 && exp_q.size() != 0; n++) step(1'b0, $urandom, 1'($urandom));
      chk("drain_done", exp_q.size(), 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int          k;
      r = $urandom;
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 3);
`else
      k = $urandom_range(0, 5);
`endif
      case (k)
         0: return {r[31:15], 3'b000, r[11:7], 7'b0010011};
         1: return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         2: return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
         3: return {r[31:15], 3'b001, r[11:7], 7'b1100011};
         4: return r;
         default: return {7'b0000001, r[24:15], 3'b000, r[11:7], 7'b0110011};
      endcase
   endfunction

   initial begin
      model_reset();
      imem_ready = 1'b1;
      instr      = I_ADDI;
      #2;
      chk("por_outputs", {23'd0, dut_vec}, 32'd0);
      chk("por_instret", instret, 32'd0);
      @(negedge clk);
      chk("in_reset_outputs", {23'd0, dut_vec}, 32'd0);
      release_reset();

      // addi x1,x0,5 with memory ready
      step(1'b1, I_ADDI, 1'b0);
      chk("addi_irwrite", {31'd0, IRWrite}, 32'd1);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      chk("addi_exec_alusrc", {30'd0, ALUsrc, ImmSrc}, 32'd2);
      step(1'b0, $urandom, 1'b0);
      chk("addi_wb", {30'd0, RegWrite, PCWrite}, 32'd3);
      step(1'b0, $urandom, 1'b0);
      chk("addi_instret", instret, 32'd1);

      // sub after three cycles of memory wait
      for (int n = 0; n < 2; n++) begin
         step(1'b0, I_SUB, 1'b0);
         chk("sub_wait", {30'd0, imem_req, IRWrite}, 32'd2);
      end
      step(1'b1, I_SUB, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      chk("sub_exec", {30'd0, ALUctrl, ALUsrc}, 32'd2);
      step(1'b0, $urandom, 1'b0);
      chk("sub_wb", {31'd0, RegWrite}, 32'd1);

      // bne taken (EQ=0) then not taken (EQ=1)
      for (int t = 0; t < 2; t++) begin
         step(1'b1, I_BNE, 1'b0);
         step(1'b0, $urandom, 1'($urandom));
         step(1'b0, $urandom, 1'(t));
         chk("bne_exec", {29'd0, PCWrite, PCsrc, RegWrite}, (t == 0) ? 32'd6 : 32'd4);
         step(1'b0, $urandom, 1'b0);
         chk("bne_next_fetch", {31'd0, imem_req}, 32'd1);
      end

      // random stream
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 9) < 7), rand_instr(), 1'($urandom));
      end
      drain();

      // instret wrap
      @(posedge clk);
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 32'hFFFF_FFFF;
      @(negedge clk);
      step(1'b1, I_ADD, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      chk("instret_wrap", instret, 32'd0);

      // reset during WB of add
      apply_reset();
      step(1'b1, I_ADD, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
      @(posedge clk);
      #1;
      chk("add_in_wb", {31'd0, RegWrite}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wb", {23'd0, dut_vec}, 32'd0);
      chk("rst_mid_instret", instret, 32'd0);
      model_reset();
      release_reset();
      step(1'b0, I_ADD, 1'b0);
      chk("after_rst_fetch", {30'd0, imem_req, IRWrite}, 32'd2);
      chk("after_rst_instret", instret, 32'd0);

      // illegal instruction
      step(1'b1, 32'h0000_0000, 1'b0);
      step(1'b0, $urandom, 1'b0);
      step(1'b0, $urandom, 1'b0);
`ifdef ILLEGAL_TRAP_EN
      for (int n = 0; n < 4; n++) begin
         step(1'b1, $urandom, 1'($urandom));
         chk("trap_hold", {30'd0, trap, imem_req}, 32'd2);
      end
`else
      chk("illegal_nop", {30'd0, PCWrite, PCsrc}, 32'd2);
      step(1'b0, $urandom, 1'b0);
      chk("illegal_next_fetch", {30'd0, imem_req, trap}, 32'd2);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
